// File: rtl/gcd_pkg.sv
// Shared types and encodings for the subtractive GCD controller and its datapath.
package gcd_pkg;

  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CMP    = 3'd3,
    SUB_A  = 3'd4,
    SUB_B  = 3'd5,
    DONE   = 3'd6
  } gcd_state_e;

  // Datapath mux encodings; the datapath decodes the same constants.
  localparam logic SEL_IN_BUS        = 1'b0;
  localparam logic SEL_IN_SUB        = 1'b1;
  localparam logic SEL_SUB_A_MINUS_B = 1'b0;
  localparam logic SEL_SUB_B_MINUS_A = 1'b1;

  function automatic logic state_is_busy(input gcd_state_e s);
    return (s != IDLE);
  endfunction

endpackage

// File: rtl/gcd_ctrl_if.sv
// Control/status bundle between the GCD controller (slave) and the datapath/requester side (master).
interface gcd_ctrl_if;
  import gcd_pkg::*;

  // start is a level request, only honoured while the controller is idle;
  // done is a single-cycle pulse, with res_sel/err valid alongside it.
  logic       start;
  logic       lt;
  logic       gt;
  logic       eq;
  logic       a_zero;
  logic       b_zero;
  logic       ld_A;
  logic       ld_B;
  logic       sel_in;
  logic       sel_sub;
  logic       busy;
  logic       done;
  logic       res_sel;
  logic       err;
  gcd_state_e dbg_state;

  modport master (
    output start, lt, gt, eq, a_zero, b_zero,
    input  ld_A, ld_B, sel_in, sel_sub, busy, done, res_sel, err, dbg_state
  );

  modport slave (
    input  start, lt, gt, eq, a_zero, b_zero,
    output ld_A, ld_B, sel_in, sel_sub, busy, done, res_sel, err, dbg_state
  );

endinterface

// File: rtl/gcd_iter_cnt.sv
// Saturating iteration counter with synchronous clear and increment.
module gcd_iter_cnt #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_limit_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == LIMIT[WIDTH-1:0]);

endmodule

// File: rtl/gcd_ctrl.sv
// Moore control FSM for the subtractive GCD datapath.
// Optional iteration timeout enabled by defining GCD_CTRL_TIMEOUT_EN.
module gcd_ctrl
  import gcd_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_ITER   = 255
) (
  input  logic       i_clk,
  input  logic       i_rst,
  gcd_ctrl_if.slave  ctrl
);

  gcd_state_e state_q, state_d;
  logic       res_sel_q, res_sel_d;
  logic       err_q, err_d;
  logic       at_limit;

  if (MAX_ITER >= (1 << DATA_WIDTH)) begin : g_bad_cfg
    $error("MAX_ITER does not fit the DATA_WIDTH-bit iteration counter");
  end

`ifdef GCD_CTRL_TIMEOUT_EN
  gcd_iter_cnt #(
    .WIDTH (DATA_WIDTH),
    .LIMIT (MAX_ITER)
  ) u_iter_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .clr_i      (state_q == LOAD_A),
    .inc_i      ((state_q == SUB_A) || (state_q == SUB_B)),
    .at_limit_o (at_limit)
  );
`else
  assign at_limit = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      res_sel_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      res_sel_q <= res_sel_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    res_sel_d = res_sel_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (ctrl.start) begin
          state_d   = LOAD_A;
          res_sel_d = 1'b0;
          err_d     = 1'b0;
        end
      end
      LOAD_A: state_d = LOAD_B;
      LOAD_B: state_d = CMP;
      CMP: begin
        // A==0 alone means B holds the answer; both zero reports A.
        if (ctrl.a_zero) begin
          state_d   = DONE;
          res_sel_d = ~ctrl.b_zero;
        end else if (ctrl.b_zero || ctrl.eq) begin
          state_d   = DONE;
          res_sel_d = 1'b0;
        end else if (at_limit) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else if (ctrl.gt) begin
          state_d = SUB_A;
        end else if (ctrl.lt) begin
          state_d = SUB_B;
        end else begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      SUB_A:   state_d = CMP;
      SUB_B:   state_d = CMP;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ctrl.ld_A      = 1'b0;
    ctrl.ld_B      = 1'b0;
    ctrl.sel_in    = SEL_IN_BUS;
    ctrl.sel_sub   = SEL_SUB_A_MINUS_B;
    ctrl.done      = 1'b0;
    ctrl.busy      = state_is_busy(state_q);
    ctrl.res_sel   = res_sel_q;
    ctrl.err       = err_q;
    ctrl.dbg_state = state_q;
    unique case (state_q)
      LOAD_A: ctrl.ld_A = 1'b1;
      LOAD_B: ctrl.ld_B = 1'b1;
      SUB_A: begin
        ctrl.ld_A    = 1'b1;
        ctrl.sel_in  = SEL_IN_SUB;
        ctrl.sel_sub = SEL_SUB_A_MINUS_B;
      end
      SUB_B: begin
        ctrl.ld_B    = 1'b1;
        ctrl.sel_in  = SEL_IN_SUB;
        ctrl.sel_sub = SEL_SUB_B_MINUS_A;
      end
      DONE:    ctrl.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/gcd_ctrl.md
# gcd_ctrl

Control FSM that sequences the subtractive GCD datapath: the two operand load registers (A, B), the input/subtractor multiplexer, and the combinational comparator. It loads both operands from the shared data bus, iterates subtract-and-compare until the operands meet, then signals completion and indicates which register holds the result. It sits beside the datapath inside the GCD top level. The datapath remains free of state-control logic.

## Interface
- DATA_WIDTH, 8: operand width. Sizes the iteration counter to DATA_WIDTH bits.
- MAX_ITER, 255: iteration limit. Used only when GCD_CTRL_TIMEOUT_EN is defined.

- i_clk  in  1  rising-edge clock, the only clock.
- i_rst  in  1  reset: asynchronous, active-high.
- start  in  1  request. Sampled only in IDLE.
- lt  in  1  comparator flag: A < B.
- gt  in  1  comparator flag: A > B.
- eq  in  1  comparator flag: A == B.
- a_zero  in  1  A register value == 0.
- b_zero  in  1  B register value == 0.
- ld_A  out  1  load enable, register A.
- ld_B  out  1  load enable, register B.
- sel_in  out  1  register input mux. 0 = data bus, 1 = subtractor output.
- sel_sub  out  1  subtractor operand order. 0 = A−B, 1 = B−A.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- res_sel  out  1  result register. 0 = A, 1 = B. Valid while done is high and held until the next start.
- err  out  1  timeout flag. Valid with done.

## Operation
- Moore FSM. All outputs decode from the registered state plus the res_sel/err registers.
- States and transitions:
  - IDLE: start=1 → LOAD_A. Otherwise stay in IDLE.
  - LOAD_A: ld_A=1, sel_in=0. The bus must carry operand A during this cycle. → LOAD_B.
  - LOAD_B: ld_B=1, sel_in=0. The bus must carry operand B during this cycle. → CMP.
  - CMP: all load enables are 0. Priority order:
    1. a_zero → DONE, res_sel=1.
    2. b_zero → DONE, res_sel=0.
    3. eq → DONE, res_sel=0.
    4. gt → SUB_A.
    5. lt → SUB_B.
    6. No flag set → DONE, err=1.
  - SUB_A: ld_A=1, sel_in=1, sel_sub=0 (A ← A−B). → CMP.
  - SUB_B: ld_B=1, sel_in=1, sel_sub=1 (B ← B−A). → CMP.
  - DONE: done=1. → IDLE.
- Both operands zero: the result is A (value 0), res_sel=0.
- start while busy is ignored. start held high in DONE takes effect only once the FSM is back in IDLE.
- The iteration counter clears on the LOAD_A entry and increments on each SUB_A/SUB_B. It saturates and never wraps.
- The result value itself lives in the datapath registers. The controller never touches the data.

## Timing
- Edge numbering: E0 is the edge that samples start=1. k is the number of SUB iterations.
  - LOAD_A during cycle E0–E1.
  - LOAD_B during cycle E1–E2.
  - First CMP starts at E2.
  - DONE is entered at edge E(2k+3) and is high for exactly one cycle.
  - The FSM returns to IDLE at E(2k+4).
- Back-to-back operation: minimum start-to-start spacing is 2k+5 edges.
- Comparator and zero flags must be settled combinationally by the end of every CMP cycle.
- Reset values: state=IDLE, ld_A=ld_B=sel_in=sel_sub=busy=done=res_sel=err=0, counter=0.
- Reset asserted mid-operation:
  - The FSM returns to IDLE immediately.
  - No done pulse is generated.
  - The datapath registers are unreset, so their contents are undefined for result purposes.

## Configuration
- GCD_CTRL_TIMEOUT_EN defined:
  - In CMP, if the counter == MAX_ITER and no terminating condition holds (a_zero, b_zero, eq), go to DONE with err=1.
  - Resulting error latency: DONE is entered at edge E(2·MAX_ITER+3).
- Not defined:
  - No iteration counter is built.
  - err is asserted only by the no-flag case in CMP.

## Structure
- Shared package gcd_pkg holds:
  - the state enumeration (IDLE, LOAD_A, LOAD_B, CMP, SUB_A, SUB_B, DONE) with fixed 3-bit binary encoding;
  - the DATA_WIDTH default;
  - the sel_in and sel_sub encoding constants, shared with the datapath muxes.
- One sub-module, gcd_iter_cnt:
  - saturating counter with clear/increment inputs and an at_limit output;
  - instantiated only under GCD_CTRL_TIMEOUT_EN.

## Test plan
- A=12, B=8 → sequence SUB_A, then SUB_B (k=2). done at E7, res_sel=0, A register=4, err=0.
- A=13, B=13 → no subtraction. done at E3, res_sel=0, result 13.
- A=0, B=9 → done at E3, res_sel=1, result 9. A=0, B=0 → done at E3, res_sel=0, result 0.
- A=255, B=1, macro off → k=254. done at E511, B register=1, err=0. Macro on with MAX_ITER=16 → done at E35, err=1.
- start pulsed during SUB_A → ignored, single done. Then i_rst asserted in the third CMP → all outputs 0 asynchronously, no done. A new start after release completes normally.
- Comparator forced to all-zero flags in CMP → done on the next edge with err=1, irrespective of the macro.
